// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, oversampling constants and parity helper
// for the uart_stream block and its sub-modules.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Parity over up to 9 data bits (callers zero-extend narrower words).
    function automatic logic parity_f(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_stream_if.sv
// uart_stream_if: TX and RX streaming handshakes of uart_stream.
// master = the user side (ADC path / host), slave = the UART itself.
interface uart_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] to_uart_data;
    logic              to_uart_valid;
    logic              to_uart_error;
    logic              to_uart_ready;
    logic [DATA_W-1:0] from_uart_data;
    logic              from_uart_error;
    logic              from_uart_valid;
    logic              from_uart_ready;

    modport master (
        output to_uart_data, to_uart_valid, to_uart_error, from_uart_ready,
        input  to_uart_ready, from_uart_data, from_uart_error, from_uart_valid
    );

    modport slave (
        input  to_uart_data, to_uart_valid, to_uart_error, from_uart_ready,
        output to_uart_ready, from_uart_data, from_uart_error, from_uart_valid
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with extra-bit pointers. The head word is
// presented combinationally and reads as zero while the FIFO is empty.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // full is judged before any same-cycle pop, so push on full is refused
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; wraps naturally modulo 2*DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/uart_stream.sv
// uart_stream: full-duplex UART with streaming TX/RX FIFOs, 16x oversampled
// receiver and per-word error flag (framing | parity | overrun).
// Optional macro UART_PARITY_EN adds a parity bit to every frame.
module uart_stream
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 27,
    parameter int STOP_BITS  = 1,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         uart_rxd,
    output logic         uart_txd,
    uart_stream_if.slave bus
);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [4:0]    BIT_END   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    MID_END   = 5'(MID_SAMPLE - 1);
    localparam logic [4:0]    STOP_END  = 5'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    logic [TW-1:0] tick_cnt_reg;
    logic          tick;

    logic              tx_full, tx_empty, tx_pop;
    logic [DATA_W:0]   tx_head;
    uart_state_e       tx_state_reg, tx_state_next;
    logic [4:0]        tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]     tx_bit_reg, tx_bit_next;
    logic [DATA_W-1:0] tx_data_reg, tx_data_next;
    logic              tx_err_reg, tx_err_next;
    logic              txd_reg, txd_next;
    logic              tx_par_bit;

    logic [1:0]        sync_reg;
    logic              rxd, rxd_prev_reg;
    uart_state_e       rx_state_reg, rx_state_next;
    logic [4:0]        rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]     rx_bit_reg, rx_bit_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic              rx_perr_reg, rx_perr_next;
    logic              rx_ferr, rx_done, rx_full, rx_empty, rx_push;
    logic              ovr_reg;

    // Free-running baud tick, one pulse every CLK_DIV clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_cnt_reg <= '0;
        else        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
    end
    assign tick = (tick_cnt_reg == TICK_LAST);

    uart_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .wr_en(bus.to_uart_valid), .wr_data({bus.to_uart_error, bus.to_uart_data}),
        .full(tx_full), .rd_en(tx_pop), .rd_data(tx_head), .empty(tx_empty)
    );
    assign bus.to_uart_ready = !tx_full;
    assign tx_par_bit = parity_f(9'(tx_data_reg), PAR_ODD) ^ tx_err_reg;
    assign uart_txd   = txd_reg;

    // TX state register; txd is registered so reset forces the line high at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_reg <= IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_data_reg  <= '0;
            tx_err_reg   <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_data_reg  <= tx_data_next;
            tx_err_reg   <= tx_err_next;
            txd_reg      <= txd_next;
        end
    end

    // TX next state: each bit lasts 16 ticks; STOP chains straight into START
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_data_next  = tx_data_reg;
        tx_err_next   = tx_err_reg;
        txd_next      = txd_reg;
        tx_pop        = 1'b0;
        if (tick) begin
            tx_cnt_next = tx_cnt_reg + 5'd1;
            case (tx_state_reg)
                IDLE: begin
                    tx_cnt_next = '0;
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_data_next  = tx_head[DATA_W-1:0];
                        tx_err_next   = tx_head[DATA_W];
                        tx_state_next = START;
                        txd_next      = 1'b0;
                    end
                end
                START: if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = DATA;
                    txd_next      = tx_data_reg[0];
                end
                DATA: if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next = '0;
                    if (tx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state_next = PARITY;
                        txd_next      = tx_par_bit;
`else
                        tx_state_next = STOP;
                        txd_next      = 1'b1;
`endif
                    end else begin
                        tx_bit_next = tx_bit_reg + BW'(1);
                        txd_next    = tx_data_reg[tx_bit_next];
                    end
                end
                PARITY: if (tx_cnt_reg == BIT_END) begin
                    tx_cnt_next   = '0;
                    tx_state_next = STOP;
                    txd_next      = 1'b1;
                end
                STOP: if (tx_cnt_reg == STOP_END) begin
                    tx_cnt_next   = '0;
                    tx_state_next = IDLE;
                    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_data_next  = tx_head[DATA_W-1:0];
                        tx_err_next   = tx_head[DATA_W];
                        tx_state_next = START;
                        txd_next      = 1'b0;
                    end
                end
                default: begin
                    tx_state_next = IDLE;
                    txd_next      = 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus previous value for start-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg     <= 2'b11;
            rxd_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= {sync_reg[0], uart_rxd};
            rxd_prev_reg <= sync_reg[1];
        end
    end
    assign rxd = sync_reg[1];

    // RX state register and sticky overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_reg <= IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_data_reg  <= '0;
            rx_perr_reg  <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_data_reg  <= rx_data_next;
            rx_perr_reg  <= rx_perr_next;
            if (rx_done) ovr_reg <= rx_full;
        end
    end

    // RX next state: mid-bit sampling; a low line after a framing error
    // produces no new falling edge, so a break yields a single word
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_data_next  = rx_data_reg;
        rx_perr_next  = rx_perr_reg;
        rx_ferr       = 1'b0;
        rx_done       = 1'b0;
        if (rx_state_reg == IDLE) begin
            if (rxd_prev_reg && !rxd) begin
                rx_state_next = START;
                rx_cnt_next   = '0;
            end
        end else if (tick) begin
            rx_cnt_next = rx_cnt_reg + 5'd1;
            case (rx_state_reg)
                START: if (rx_cnt_reg == MID_END) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_perr_next  = 1'b0;
                    rx_state_next = rxd ? IDLE : DATA;
                end
                DATA: if (rx_cnt_reg == BIT_END) begin
                    rx_cnt_next  = '0;
                    rx_data_next = {rxd, rx_data_reg[DATA_W-1:1]};
                    if (rx_bit_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_next = PARITY;
`else
                        rx_state_next = STOP;
`endif
                    end else begin
                        rx_bit_next = rx_bit_reg + BW'(1);
                    end
                end
                PARITY: if (rx_cnt_reg == BIT_END) begin
                    rx_cnt_next   = '0;
                    rx_perr_next  = (rxd != parity_f(9'(rx_data_reg), PAR_ODD));
                    rx_state_next = STOP;
                end
                STOP: if (rx_cnt_reg == BIT_END) begin
                    rx_ferr       = !rxd;
                    rx_done       = 1'b1;
                    rx_state_next = IDLE;
                end
                default: rx_state_next = IDLE;
            endcase
        end
    end

    // A word arriving into a full RX FIFO is dropped; ovr marks the next one
    assign rx_push = rx_done && !rx_full;

    uart_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .wr_en(rx_push), .wr_data({rx_ferr | rx_perr_reg | ovr_reg, rx_data_reg}),
        .full(rx_full), .rd_en(bus.from_uart_ready),
        .rd_data({bus.from_uart_error, bus.from_uart_data}), .empty(rx_empty)
    );
    assign bus.from_uart_valid = !rx_empty;
endmodule

// File: tb/tb_uart_stream.sv
// tb_uart_stream: directed bench for uart_stream (CLK_DIV=4, 4-deep FIFOs).
// Expectations follow the UART_PARITY_EN macro when it is defined.
`timescale 1ns/1ps
module tb_uart_stream;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int BIT_CLK = 16 * CLK_DIV;     // 64 clk per bit
`ifdef UART_PARITY_EN
    localparam int FRAME_CLK = 11 * BIT_CLK;   // 704
    localparam logic PAR_BIT1 = 1'b0;          // 0x01, error injected
    localparam logic ERR1     = 1'b1;
    localparam logic PAR_BIT0 = 1'b1;          // 0x01, clean even parity
`else
    localparam int FRAME_CLK = 10 * BIT_CLK;   // 640
    localparam logic PAR_BIT1 = 1'b1;          // slot 9 is the stop bit
    localparam logic ERR1     = 1'b0;
    localparam logic PAR_BIT0 = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_rxd;
    logic uart_txd;
    logic rxd_tb = 1'b1;
    logic loop_en = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fall_q[$];
    logic txd_last = 1'b1;

    uart_stream_if #(.DATA_W(8)) bus ();

    uart_stream #(
        .DATA_W(8), .CLK_DIV(CLK_DIV), .STOP_BITS(1),
        .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .bus(bus)
    );

    assign uart_rxd = loop_en ? uart_txd : rxd_tb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // record the cycle of every falling edge of txd
    always @(negedge clk) begin
        if (txd_last && !uart_txd) fall_q.push_back(cyc);
        txd_last <= uart_txd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        int n = 0;
        bus.to_uart_data  = d;
        bus.to_uart_error = e;
        bus.to_uart_valid = 1'b1;
        while (!bus.to_uart_ready && n < 3000) begin @(negedge clk); n++; end
        check("push_ready", bus.to_uart_ready, 1);
        @(negedge clk);
        bus.to_uart_valid = 1'b0;
        $display("push data=%02h err=%0d", d, e);
    endtask

    task automatic pop(input string tag, input logic [7:0] d, input logic e);
        int n = 0;
        while (!bus.from_uart_valid && n < 3000) begin @(negedge clk); n++; end
        check({tag, "_valid"}, bus.from_uart_valid, 1);
        check({tag, "_data"}, bus.from_uart_data, d);
        check({tag, "_err"}, bus.from_uart_error, e);
        $display("pop  data=%02h err=%0d (%s)", bus.from_uart_data, bus.from_uart_error, tag);
        bus.from_uart_ready = 1'b1;
        @(negedge clk);
        bus.from_uart_ready = 1'b0;
    endtask

    task automatic wait_fall(input int base, output int t0);
        int n = 0;
        while (fall_q.size() <= base && n < 2000) begin @(negedge clk); n++; end
        check("txd_start_seen", fall_q.size() > base, 1);
        t0 = (fall_q.size() > base) ? fall_q[base] : cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxd_tb = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_tb = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rxd_tb = ^d;
        repeat (BIT_CLK) @(negedge clk);
`endif
        rxd_tb = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        $display("sent frame data=%02h stop=%0d", d, stop_bit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        bus.to_uart_data    = '0;
        bus.to_uart_valid   = 1'b0;
        bus.to_uart_error   = 1'b0;
        bus.from_uart_ready = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_from_valid", bus.from_uart_valid, 0);
        check("rst_from_data", bus.from_uart_data, 0);
        check("rst_from_err", bus.from_uart_error, 0);
        check("rst_to_ready", bus.to_uart_ready, 1);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // loopback, back-to-back frames with no idle gap
        base = fall_q.size();
        push(8'hA5, 1'b0);
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        wait_fall(base, t0);
        wait_until(t0 + BIT_CLK + 32);      check("a5_bit0", uart_txd, 1);
        wait_until(t0 + 2 * BIT_CLK + 32);  check("a5_bit1", uart_txd, 0);
        wait_until(t0 + FRAME_CLK - 32);    check("f1_stop", uart_txd, 1);
        wait_until(t0 + FRAME_CLK + 32);    check("f2_start", uart_txd, 0);
        wait_until(t0 + 2 * FRAME_CLK + 32); check("f3_start", uart_txd, 0);
        wait_until(t0 + 3 * FRAME_CLK + 32); check("idle_after", uart_txd, 1);
        pop("lb_a5", 8'hA5, 1'b0);
        pop("lb_00", 8'h00, 1'b0);
        pop("lb_ff", 8'hFF, 1'b0);

        // framing error followed by a break: exactly one error word
        loop_en = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        send_frame(8'h3C, 1'b0);
        repeat (3 * BIT_CLK) @(negedge clk);
        rxd_tb = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        pop("ferr", 8'h3C, 1'b1);
        check("ferr_single", bus.from_uart_valid, 0);

        // parity bit: injected error, then clean
        loop_en = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        base = fall_q.size();
        push(8'h01, 1'b1);
        wait_fall(base, t0);
        wait_until(t0 + 9 * BIT_CLK + 32);  check("par_bad_bit", uart_txd, PAR_BIT1);
        pop("par_bad", 8'h01, ERR1);
        repeat (BIT_CLK) @(negedge clk);
        base = fall_q.size();
        push(8'h01, 1'b0);
        wait_fall(base, t0);
        wait_until(t0 + 9 * BIT_CLK + 32);  check("par_ok_bit", uart_txd, PAR_BIT0);
        pop("par_ok", 8'h01, 1'b0);

        // overrun: DEPTH+2 frames with the consumer stalled
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DEPTH + 2; i++) push(8'h10 + 8'(i), 1'b0);
        repeat (6 * FRAME_CLK) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) pop("ovr_keep", 8'h10 + 8'(i), 1'b0);
        check("ovr_dropped", bus.from_uart_valid, 0);
        push(8'h20, 1'b0);
        pop("ovr_flag", 8'h20, 1'b1);
        push(8'h21, 1'b0);
        pop("ovr_clear", 8'h21, 1'b0);

        // 3-clk glitch must not start a frame
        loop_en = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rxd_tb = 1'b0;
        repeat (3) @(negedge clk);
        rxd_tb = 1'b1;
        repeat (5 * BIT_CLK) @(negedge clk);
        check("glitch_no_word", bus.from_uart_valid, 0);
        send_frame(8'h5A, 1'b1);
        rxd_tb = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("after_glitch_valid", bus.from_uart_valid, 1);
        check("after_glitch_data", bus.from_uart_data, 8'h5A);

        // reset mid-DATA of a TX frame (0x5A left queued in RX on purpose)
        loop_en = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        base = fall_q.size();
        push(8'hC3, 1'b0);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        check("tx_full_ready", bus.to_uart_ready, 0);
        wait_fall(base, t0);
        wait_until(t0 + 3 * BIT_CLK + 32);  check("c3_bit2", uart_txd, 0);
        check("pre_rst_valid", bus.from_uart_valid, 1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_txd", uart_txd, 1);
        check("mid_rst_ready", bus.to_uart_ready, 1);
        check("mid_rst_valid", bus.from_uart_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        base = fall_q.size();
        push(8'h96, 1'b0);
        wait_fall(base, t0);
        wait_until(t0 + 32);                check("post_rst_start", uart_txd, 0);
        wait_until(t0 + BIT_CLK + 32);      check("post_rst_bit0", uart_txd, 0);
        wait_until(t0 + 2 * BIT_CLK + 32);  check("post_rst_bit1", uart_txd, 1);
        pop("post_rst", 8'h96, 1'b0);
        check("post_rst_only", bus.from_uart_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_stream.md
Name: uart_stream

Overview:
Parametrised successor to the fixed 8N1 UART stream block. It provides full-duplex serial TX and RX with streaming valid/ready interfaces, a generic data width, and a runtime-free divisor-based baud generator with 16x RX oversampling. Independent TX and RX FIFOs are included, along with per-byte error reporting covering framing, parity and overrun. It sits between the ADC data path and the host serial link.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
CLK_DIV, 27, clk cycles per 1/16 bit period; must be >= 1 (50 MHz / (115200*16) ≈ 27)
STOP_BITS, 1, TX stop bits (1 or 2); RX checks only the first stop bit
TX_DEPTH, 16, TX FIFO entries (power of 2, >= 2)
RX_DEPTH, 16, RX FIFO entries (power of 2, >= 2)
PARITY_ODD, 0, 0 = even, 1 = odd; used only when UART_PARITY_EN is defined

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; all state clears while low
uart_rxd  in  1  serial input; asynchronous to clk, idles high
uart_txd  out  1  serial output; idles high
to_uart_data  in  DATA_W  TX word
to_uart_valid  in  1  TX word valid
to_uart_error  in  1  with the word: send a deliberately wrong parity bit
to_uart_ready  out  1  TX FIFO not full
from_uart_data  out  DATA_W  RX word
from_uart_error  out  1  RX word had a framing, parity or overrun error
from_uart_valid  out  1  RX FIFO not empty
from_uart_ready  in  1  consumer accepts the RX word

Behaviour:
- Reset values: uart_txd=1, from_uart_valid=0, from_uart_data=0, from_uart_error=0, to_uart_ready=1. FIFOs are emptied, FSMs return to IDLE, the tick counter is 0. A reset asserted mid-frame aborts the frame immediately and uart_txd goes high asynchronously.
- Tick generator: free-running counter 0..CLK_DIV-1. It emits a one-cycle tick at CLK_DIV-1. One bit = 16 ticks = 16*CLK_DIV clk.
- Handshake (both sides): a transfer occurs on a clk edge where valid && ready. Data must hold while valid && !ready.
  - TX accept is registered into the FIFO, so write-to-read latency is 1 clk.
  - On RX, data, error and valid come directly from the FIFO head. A pop on transfer exposes the next entry on the following cycle.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, pop on the next tick and go to START with txd=0.
  - Each state holds for 16 ticks.
  - DATA shifts DATA_W bits LSB first.
  - PARITY: txd = XOR(data) ^ PARITY_ODD ^ stored to_uart_error bit.
  - STOP: txd=1 for STOP_BITS*16 ticks, then IDLE. Back-to-back words produce no idle gap.
- RX front end: 2-flop synchroniser on uart_rxd (adds 2 clk latency).
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on a synchronised 1-to-0 edge; the tick phase counter resets at that edge.
  - START: at tick 8, if rxd=1 it is a glitch, return to IDLE with no write; else continue.
  - DATA: sample at tick 16 of each bit (mid-bit).
  - PARITY: compare against the computed value; a mismatch sets perr.
  - STOP: at mid-bit, rxd=0 sets ferr. Write {err, data} to the RX FIFO, then go to IDLE.
  - After a framing error, RX waits for rxd=1 before re-arming, so a break produces one error word only.
- Overrun: a word arriving with the RX FIFO full is dropped, and a sticky ovr flag is set. The next successfully written word carries error=1, and ovr clears on that write.
- Error bit per word = ferr | perr | ovr.
- Simultaneous push and pop on a full FIFO: the pop frees space, but the push is still refused because full is sampled before the pop. Simultaneous push and pop on an empty FIFO: valid rises the next cycle.
- FIFO pointers are one bit wider than the address and wrap modulo 2*DEPTH. full and empty are registered-equivalent and derived from the pointers.

Optional Feature:
UART_PARITY_EN:
- Defined: PARITY state is present on TX and RX. perr is checked. to_uart_error corrupts the TX parity bit.
- Undefined: PARITY state is removed and frames are D-N-S. perr is held 0. to_uart_error is accepted and ignored.

Decomposition:
- Package uart_pkg contains:
  - enum uart_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparam OVERSAMPLE=16 and MID_SAMPLE=8
  - function parity_f(data, odd)
- Sub-module uart_sync_fifo (WIDTH, DEPTH), instantiated twice: TX with WIDTH=DATA_W+1, RX with WIDTH=DATA_W+1.

Test Plan:
- Loopback txd to rxd, CLK_DIV=4, push 0xA5, 0x00, 0xFF back-to-back -> RX yields the same three words, error=0. Each frame is 640 clk without parity, 704 clk with parity, and there are no idle gaps.
- Drive a stop bit of 0 on 0x3C -> from_uart_data=0x3C, from_uart_error=1. The RX FSM holds in IDLE until rxd=1 and produces one error word only.
- UART_PARITY_EN, even parity, send 0x01 with to_uart_error=1 -> the TX parity bit is 0 and the RX word has error=1. Repeat with to_uart_error=0 -> error=0.
- from_uart_ready=0, send RX_DEPTH+2 frames -> the first RX_DEPTH words are intact and 2 words are dropped. After draining, the next received word has error=1 and the following word has error=0.
- 3-clk low glitch on rxd with CLK_DIV=4 -> no FIFO write and from_uart_valid stays 0.
- Assert reset mid-DATA of a TX frame -> txd=1 immediately, to_uart_ready=1, from_uart_valid=0. After release, the next pushed word transmits with a clean start bit.
